ring_reader: RTL
================

Name: ring_reader

Overview:
- Read-side sequencer for a circular RAM buffer.
- The write side advances a wrapping address counter; each write strobe is mirrored into this block's `wr_en`.
- This block tracks the number of unread entries and issues RAM reads with a wrapping read address.
- It captures RAM read data (1-cycle RAM latency) into a 3-entry output buffer, presented on a valid/ready stream. Full throughput is sustained with no combinational ready-to-read path.

Parameters:
- ADDR_WIDTH, 3, width of the RAM address / read pointer.
- ADDR_LAST, 7, last valid address; the pointer wraps ADDR_LAST -> 0. Capacity is ADDR_LAST+1 entries.
- DATA_WIDTH, 8, RAM word and output data width.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- wr_en  input  1  one entry has been written to the RAM this cycle (mirrors the writer's counter enable).
- rd_en  output  1  RAM read strobe, combinational from registered state.
- rd_addr  output  ADDR_WIDTH  current read pointer (registered); address of the read issued when rd_en=1.
- ram_rdata  input  DATA_WIDTH  RAM read data, valid the cycle after rd_en.
- out_data  output  DATA_WIDTH  head of the output buffer.
- out_valid  output  1  output buffer non-empty.
- out_ready  input  1  consumer accepts out_data when out_valid=1.
- level  output  ADDR_WIDTH+1  unread entries still in RAM (0..ADDR_LAST+1).
- empty  output  1  level==0.
- overflow  output  1  sticky; a write arrived while the RAM was full.

Behaviour:
- Interface: reset is synchronous, active-high; clock clk.
- Reset values:
  - level=0, rd_addr=0, rd_pending=0, buffer count=0.
  - out_valid=0, out_data=0, overflow=0, empty=1, rd_en=0.
- Reset mid-operation: an in-flight read is discarded; ram_rdata in the following cycle is ignored.
- Read issue: rd_en = (level!=0) && (buf_count + rd_pending < 3).
  - rd_pending is a 1-bit register, set to rd_en each cycle.
  - rd_en does not depend on out_ready.
- On rd_en:
  - rd_addr <= (rd_addr==ADDR_LAST) ? 0 : rd_addr+1.
  - level decrements unless wr_en is also 1.
- Level update:
  - wr_en && !rd_en && level<ADDR_LAST+1: level+1.
  - wr_en && rd_en: level unchanged.
  - wr_en && !rd_en && level==ADDR_LAST+1: level holds and overflow<=1 (sticky until reset).
  - Underflow is impossible: rd_en is gated by level!=0.
- Capture: when rd_pending=1, ram_rdata is pushed into the output buffer at the end of that cycle.
- Output buffer:
  - 3-entry FIFO, in order.
  - out_valid = buf_count!=0; out_data = head entry (0 when empty is acceptable).
  - Pop on out_valid && out_ready.
  - Push and pop in the same cycle leave count unchanged.
  - Push never occurs when full, guaranteed by the credit rule.
- Latency: rd_en in cycle T -> data captured at the end of T+1 -> out_valid=1 in T+2 if the buffer was empty.
- Throughput: with out_ready held 1 and level>0, one rd_en and one pop per cycle in steady state.
- Backpressure: with out_ready=0, at most 3 reads are issued (buffer plus pending); rd_en then stays 0 until a pop.
- Wrap: rd_addr sequence is 0..ADDR_LAST,0,... and is independent of level wrap.
- ADDR_LAST+1 may be less than 2**ADDR_WIDTH; rd_addr never exceeds ADDR_LAST.

Test Plan:
- Reset: assert reset 2 cycles with random inputs -> all outputs at reset values; ram_rdata toggling has no effect.
- Basic read: wr_en 3 cycles (cycles 0-2), out_ready=1, RAM model returns 0xA0+addr -> rd_en at cycles 1,2,3 with rd_addr 0,1,2; out_data 0xA0,0xA1,0xA2 valid at cycles 3,4,5; level ends 0, empty=1.
- Wrap + throughput: 16 writes at 1/cycle with out_ready=1 -> rd_addr 0..7,0..7; 16 outputs in order, one per cycle after initial latency; overflow=0.
- Backpressure: out_ready=0, 8 writes -> exactly 3 rd_en, level=5, out_valid=1. Then set out_ready=1 -> 8 items in order, level reaches 0.
- Full/overflow: out_ready=0, 11 writes (8+3 drained into buffer), then one extra wr_en -> level stays 8, overflow=1 and remains 1; simultaneous wr_en&&rd_en at level 5 -> level stays 5.
- Reset mid-flight: assert reset in the cycle right after rd_en -> next-cycle ram_rdata not captured; out_valid=0, level=0, rd_addr=0.

Source files
------------

// File: rtl/ring_reader.sv
// Read sequencer for a circular RAM buffer, feeding a 3-entry valid/ready output queue.
// Read credit counts buffered plus in-flight words, so out_ready never reaches rd_en combinationally.
module ring_reader #(
  parameter int ADDR_WIDTH = 3,
  parameter int ADDR_LAST  = 7,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  empty,
  output logic                  overflow
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(ADDR_LAST);
  localparam logic [ADDR_WIDTH:0]   CAPACITY  = (ADDR_WIDTH+1)'(ADDR_LAST + 1);

  logic [ADDR_WIDTH:0]   level_q, level_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                  rd_pending_q, rd_pending_d;
  logic                  overflow_q, overflow_d;
  logic [1:0]            buf_count_q, buf_count_d;
  logic [1:0]            head_q, head_d;
  logic [1:0]            tail_q, tail_d;
  logic [DATA_WIDTH-1:0] buf_mem_q [3];
  logic [DATA_WIDTH-1:0] buf_mem_d [3];
  logic                  push;
  logic                  pop;

  function automatic logic [1:0] next_idx(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

  // A read is only issued when its word is guaranteed a buffer slot on arrival.
  assign rd_en     = (level_q != '0) &&
                     (({1'b0, buf_count_q} + {2'b00, rd_pending_q}) < 3'd3);
  assign push      = rd_pending_q;
  assign out_valid = (buf_count_q != 2'd0);
  assign pop       = out_valid && out_ready;

  assign rd_addr  = rd_addr_q;
  assign level    = level_q;
  assign empty    = (level_q == '0);
  assign overflow = overflow_q;
  assign out_data = out_valid ? buf_mem_q[head_q] : '0;

  always_comb begin
    level_d      = level_q;
    rd_addr_d    = rd_addr_q;
    rd_pending_d = rd_en;
    overflow_d   = overflow_q;
    buf_count_d  = buf_count_q;
    head_d       = head_q;
    tail_d       = tail_q;
    buf_mem_d    = buf_mem_q;

    if (rd_en) begin
      rd_addr_d = (rd_addr_q == LAST_ADDR) ? '0 : rd_addr_q + 1'b1;
    end

    if (wr_en && !rd_en) begin
      if (level_q == CAPACITY) begin
        overflow_d = 1'b1;
      end else begin
        level_d = level_q + 1'b1;
      end
    end else if (!wr_en && rd_en) begin
      level_d = level_q - 1'b1;
    end

    if (push) begin
      buf_mem_d[tail_q] = ram_rdata;
      tail_d            = next_idx(tail_q);
    end
    if (pop) begin
      head_d = next_idx(head_q);
    end
    case ({push, pop})
      2'b10:   buf_count_d = buf_count_q + 2'd1;
      2'b01:   buf_count_d = buf_count_q - 2'd1;
      default: buf_count_d = buf_count_q;
    endcase
  end

  // Clearing rd_pending drops any word still in flight from the RAM.
  always_ff @(posedge clk) begin
    if (reset) begin
      level_q      <= '0;
      rd_addr_q    <= '0;
      rd_pending_q <= 1'b0;
      overflow_q   <= 1'b0;
      buf_count_q  <= 2'd0;
      head_q       <= 2'd0;
      tail_q       <= 2'd0;
      buf_mem_q    <= '{default: '0};
    end else begin
      level_q      <= level_d;
      rd_addr_q    <= rd_addr_d;
      rd_pending_q <= rd_pending_d;
      overflow_q   <= overflow_d;
      buf_count_q  <= buf_count_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      buf_mem_q    <= buf_mem_d;
    end
  end

endmodule
